// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Captures a NUM_DIGITS*4-bit hex value on a load strobe into a shadow register and
// drives one digit per refresh slot. It supports a per-digit enable mask, leading-zero
// blanking, per-digit blink and a selectable output polarity.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   load, data  capture strobe and hex value (nibble k shown on digit k, digit 0 rightmost)
//   digit_en    per-digit enable mask
//   blink_en    per-digit blink select
//   lzb         leading-zero blanking enable
//   a_to_g      segments [6]=a .. [0]=g, registered
//   num_en      digit selects (one-hot or none), registered
//   slot_tick   1-cycle pulse in the last cycle of each digit slot, registered
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 256,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   num_en,
  output logic                    slot_tick
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_on_q, phase_on_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [6:0]            a_to_g_q, a_to_g_d;
  logic [NUM_DIGITS-1:0] num_en_q, num_en_d;
  logic                  slot_tick_q, slot_tick_d;

  logic                  tick_c;
  logic [3:0]            nib_c;
  logic [NUM_DIGITS-1:0] blanked_c;
  logic [NUM_DIGITS-1:0] lit_c;
  logic                  zeros_above_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] sel_c;

  // Active-high abcdefg hex decode.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Prescaler, digit index, blink counter/phase and shadow register.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    phase_on_d = phase_on_q;
    shadow_d   = shadow_q;

    tick_c = (presc_q == PW'(REFRESH_DIV - 1));

    if (tick_c) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d     = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (load) begin
      shadow_d = data;
    end

    // Registered so that it is high exactly while the prescaler sits at its last count.
    slot_tick_d = (presc_d == PW'(REFRESH_DIV - 1));
  end

  // Pin values for the current index, built from present state so that the index and the
  // shadow value reach the pins together.
  always_comb begin
    nib_c         = 4'h0;
    blanked_c     = '0;
    lit_c         = '0;
    sel_c         = '0;
    zeros_above_c = 1'b1;

    // Walk from the most significant digit down: a digit is blanked while it and every digit above it are zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeros_above_c = zeros_above_c & (shadow_q[4*k +: 4] == 4'h0);
      blanked_c[k]  = lzb & zeros_above_c & (k != 0);
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      lit_c[k] = digit_en[k] & ~(blink_en[k] & ~phase_on_q) & ~blanked_c[k];
      if (idx_q == IW'(k)) begin
        nib_c    = shadow_q[4*k +: 4];
        sel_c[k] = lit_c[k];
      end
    end

    // An unlit slot turns off the segments as well as the select, so no digit ghosts.
    seg_c = (|sel_c) ? hex_decode(nib_c) : 7'h00;

    a_to_g_d = ACTIVE_LOW ? ~seg_c : seg_c;
    num_en_d = ACTIVE_LOW ? ~sel_c : sel_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      phase_on_q  <= 1'b1;
      shadow_q    <= '0;
      a_to_g_q    <= SEG_OFF;
      num_en_q    <= DIG_OFF;
      slot_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      phase_on_q  <= phase_on_d;
      shadow_q    <= shadow_d;
      a_to_g_q    <= a_to_g_d;
      num_en_q    <= num_en_d;
      slot_tick_q <= slot_tick_d;
    end
  end

  assign a_to_g    = a_to_g_q;
  assign num_en    = num_en_q;
  assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 2-slot blink half-period, active-low).
// The reference derives slot, digit index and blink phase from a count of cycles since reset.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned BD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic        lzb;
  logic [6:0]  a_to_g;
  logic [3:0]  num_en;
  logic        slot_tick;

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset and the captured value.
  int          cyc;
  logic [15:0] shadow;
  logic [6:0]  seg_tab [16];

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .digit_en (digit_en),
    .blink_en (blink_en),
    .lzb      (lzb),
    .a_to_g   (a_to_g),
    .num_en   (num_en),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock: predict pins from the pre-edge state, advance the reference, then compare.
  task automatic step();
    logic [6:0] es;
    logic [3:0] ee;
    logic       et;
    int         slots;
    int         idx;
    bit         off;
    bit         blanked;
    bit         lit;
    logic [3:0] nib;
    es = 7'h7F;
    ee = 4'hF;
    if (!reset) begin
      slots   = cyc / RD;
      idx     = slots % ND;
      off     = ((slots / BD) % 2) == 1;
      nib     = shadow[4*idx +: 4];
      blanked = lzb && (idx != 0) && ((shadow >> (4 * idx)) == 16'h0);
      lit     = digit_en[idx] && !(blink_en[idx] && off) && !blanked;
      if (lit) begin
        es = ~seg_tab[nib];
        ee = ~(4'(1) << idx);
      end
    end
    if (reset) begin
      cyc    = 0;
      shadow = 16'h0;
    end else begin
      cyc++;
      if (load) shadow = data;
    end
    et = !reset && ((cyc % RD) == RD - 1);
    @(posedge clk);
    #1;
    check("a_to_g", 32'(a_to_g), 32'(es));
    check("num_en", 32'(num_en), 32'(ee));
    check("slot_tick", 32'(slot_tick), 32'(et));
  endtask

  task automatic load_value(input logic [15:0] v);
    data = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    cyc      = 0;
    shadow   = 16'h0;
    reset    = 1'b1;
    load     = 1'b0;
    data     = 16'h0;
    digit_en = 4'hF;
    blink_en = 4'h0;
    lzb      = 1'b0;

    // Reset hold and free-running scan of a zero value.
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();

    // Plain hex display.
    load_value(16'h12AF);
    repeat (20) step();

    // Leading-zero blanking on and off.
    lzb = 1'b1;
    load_value(16'h0005);
    repeat (20) step();
    lzb = 1'b0;
    repeat (20) step();

    // All-zero value: digit 0 survives blanking unless masked.
    lzb = 1'b1;
    load_value(16'h0000);
    repeat (20) step();
    digit_en = 4'b1110;
    repeat (20) step();
    digit_en = 4'hF;
    lzb      = 1'b0;

    // Blink on digit 0 only.
    load_value(16'h4321);
    blink_en = 4'b0001;
    repeat (40) step();
    blink_en = 4'h0;

    // Load in the same cycle as slot_tick.
    for (int i = 0; i < 8 && (cyc % RD) != RD - 1; i++) step();
    load_value(16'hBEEF);
    repeat (8) step();

    // Reset mid-slot, with and without a concurrent load.
    for (int i = 0; i < 8 && (cyc % RD) != 1; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    data  = 16'hFFFF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    reset = 1'b0;
    repeat (10) step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 3) == 0);
      data     = 16'($urandom) >> (4 * $urandom_range(0, 4));
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      blink_en = 4'($urandom);
      lzb      = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
